vga_timing_monitor: RTL and testbench
=====================================

// Module: vga_timing_monitor
// PURPOSE
//  Sink-side checker for the VGA_HS / VGA_VS / data_en stream produced by vga_controller.
//  Recovers the pixel coordinate of each active pixel and measures line/frame timing.
//  Declares lock once a full frame matches the configured mode, and flags any later deviation.
//  Sits beside the VGA pins (or in the bench) in the pixel_clk domain.
//  Inputs are synchronous to pixel_clk, so there are no synchroniser flops.
// PARAMETERS
//  H_ACTIVE   640  expected data_en-high cycles per line
//  H_TOTAL    800  expected pixel_clk cycles between HS leading edges
//  V_ACTIVE   480  expected lines with data_en per frame
//  V_TOTAL    525  expected HS leading edges between VS leading edges
//  HS_POL     0    sync active level of VGA_HS (0 = active-low)
//  VS_POL     0    sync active level of VGA_VS (0 = active-low)
//  CW         12   width of all internal counters/measurements
// PORTS
//  pixel_clk     in   1   clock; all logic on rising edge
//  rst           in   1   synchronous, active-high reset
//  VGA_HS        in   1   horizontal sync from vga_controller
//  VGA_VS        in   1   vertical sync from vga_controller
//  data_en       in   1   active-video enable from vga_controller
//  pix_valid     out  1   registered copy of data_en
//  pix_x         out  CW  column of current active pixel, 0-based
//  pix_y         out  CW  row of current active pixel, 0-based
//  line_start    out  1   1-cycle pulse with first pix_valid of each line
//  frame_start   out  1   1-cycle pulse with pixel (0,0) of each frame
//  meas_h_active out  CW  data_en-high count of last completed line
//  meas_h_total  out  CW  cycle count of last completed line (HS edge to HS edge)
//  meas_v_active out  CW  active-line count of last completed frame
//  meas_v_total  out  CW  line count of last completed frame
//  locked        out  1   timing matches parameters
//  timing_err    out  1   1-cycle pulse on any mismatch in MEASURE or LOCKED
// BEHAVIOUR
//  - Reset: all outputs 0, every counter 0, FSM=SEARCH, previous-level registers = inactive.
//    Reset has priority at any point, including mid-frame.
//  - Sync leading edge = previous level inactive AND current level == *_POL.
//  - Coordinates: latency 1 cycle. For each cycle data_en is sampled 1:
//    - Next cycle: pix_valid=1.
//    - pix_x = 0 if data_en was 0 on the previous edge, else pix_x+1.
//  - Row tracking: a VS leading edge arms new_frame.
//    - First data_en rising edge after arming: pix_y=0, frame_start=1, new_frame cleared.
//    - Other data_en rising edges: pix_y+1.
//    - line_start=1 on every data_en rising edge.
//  - Measurement:
//    - h_cnt counts cycles. On an HS leading edge: meas_h_total<=h_cnt+1, h_cnt<=0.
//    - de_cnt counts data_en-high cycles. On a data_en falling edge: meas_h_active<=de_cnt, de_cnt<=0.
//    - Line and DE-line counters are captured into meas_v_total / meas_v_active and cleared on a VS leading edge.
//    - All counters saturate at 2^CW-1; they never wrap.
//  - Checks (active in MEASURE and LOCKED):
//    - Each meas_h_total update vs H_TOTAL.
//    - Each meas_h_active update vs H_ACTIVE.
//    - Each VS-edge frame capture vs V_TOTAL / V_ACTIVE.
//    - The first HS edge after leaving SEARCH is not checked (partial line).
//  - FSM:
//    - SEARCH:  on VS leading edge -> MEASURE, clear bad flag.
//    - MEASURE: any mismatch sets sticky bad flag and pulses timing_err.
//      At next VS leading edge: bad=0 -> LOCKED (locked=1 the next cycle); bad=1 -> SEARCH.
//    - LOCKED:  any mismatch -> timing_err pulse, locked=0 the same cycle as the pulse, -> SEARCH.
//  - Simultaneous HS and VS leading edges: the line capture happens first, and the frame count includes that line.
//  - data_en stuck 0: no pix_valid; caught by the V_ACTIVE check.
// TESTING
//  1 rst held 20 cycles mid-line -> all outputs 0 next cycle; FSM SEARCH; no timing_err.
//  2 nominal 640x480 stream, 3 frames -> locked=1 one cycle after 2nd VS leading edge;
//    meas_* = 640/800/480/525; timing_err never 1.
//  3 during locked frame -> pix_x runs 0..639 per line; pix_y 0..479;
//    frame_start exactly once per frame, at (0,0); line_start 480 times per frame.
//  4 one line with data_en shortened to 639 cycles -> timing_err pulse at its falling edge;
//    locked=0; relock after two clean VS edges.
//  5 one frame with 524 lines -> timing_err at next VS edge; FSM returns to SEARCH.
//  6 VGA_HS held inactive 5000 cycles -> h_cnt saturates at 4095 (CW=12), no wrap;
//    mismatch flagged at next HS edge.

Source files
------------

// File: rtl/vga_timing_monitor.sv
// Sink-side checker for a VGA HS/VS/data_en stream: recovers pixel coordinates,
// measures line/frame timing, and reports lock and any later timing deviation.
module vga_timing_monitor #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_TOTAL  = 800,
  parameter int   V_ACTIVE = 480,
  parameter int   V_TOTAL  = 525,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CW       = 12
) (
  input  logic          pixel_clk,
  input  logic          rst,
  input  logic          VGA_HS,
  input  logic          VGA_VS,
  input  logic          data_en,
  output logic          pix_valid,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          line_start,
  output logic          frame_start,
  output logic [CW-1:0] meas_h_active,
  output logic [CW-1:0] meas_h_total,
  output logic [CW-1:0] meas_v_active,
  output logic [CW-1:0] meas_v_total,
  output logic          locked,
  output logic          timing_err
);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  localparam logic [CW-1:0] CNT_MAX = '1;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  state_t        state, state_nxt;
  logic          bad, bad_nxt, skip_h, skip_nxt;
  logic          hs_prev, vs_prev, de_prev, new_frame;
  logic          hs_edge, vs_edge, de_rise, de_fall;
  logic          h_bad, a_bad, v_bad, mismatch;
  logic [CW-1:0] h_cnt, de_cnt, v_cnt, va_cnt;
  logic [CW-1:0] h_total_nxt, v_total_nxt, v_active_nxt;

  always_comb begin
    hs_edge      = (hs_prev != HS_POL) && (VGA_HS == HS_POL);
    vs_edge      = (vs_prev != VS_POL) && (VGA_VS == VS_POL);
    de_rise      = data_en && !de_prev;
    de_fall      = !data_en && de_prev;
    h_total_nxt  = sat_inc(h_cnt);
    // A line ending on the same cycle as the frame still belongs to that frame
    v_total_nxt  = hs_edge ? sat_inc(v_cnt) : v_cnt;
    v_active_nxt = de_rise ? sat_inc(va_cnt) : va_cnt;
    h_bad        = hs_edge && !skip_h && (h_total_nxt != CW'(H_TOTAL));
    a_bad        = de_fall && (de_cnt != CW'(H_ACTIVE));
    v_bad        = vs_edge && ((v_total_nxt != CW'(V_TOTAL)) ||
                               (v_active_nxt != CW'(V_ACTIVE)));
    mismatch     = (state != SEARCH) && (h_bad || a_bad || v_bad);
  end

  always_comb begin
    state_nxt = state;
    bad_nxt   = bad;
    skip_nxt  = skip_h && !hs_edge;
    case (state)
      SEARCH: begin
        if (vs_edge) begin
          state_nxt = MEASURE;
          bad_nxt   = 1'b0;
          skip_nxt  = 1'b1;
        end
      end
      MEASURE: begin
        if (mismatch) bad_nxt = 1'b1;
        if (vs_edge) state_nxt = (bad || mismatch) ? SEARCH : LOCKED;
      end
      LOCKED: begin
        if (mismatch) state_nxt = SEARCH;
      end
      default: state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state  <= SEARCH;
      bad    <= 1'b0;
      skip_h <= 1'b0;
    end else begin
      state  <= state_nxt;
      bad    <= bad_nxt;
      skip_h <= skip_nxt;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      hs_prev       <= ~HS_POL;
      vs_prev       <= ~VS_POL;
      de_prev       <= 1'b0;
      new_frame     <= 1'b0;
      pix_valid     <= 1'b0;
      pix_x         <= '0;
      pix_y         <= '0;
      line_start    <= 1'b0;
      frame_start   <= 1'b0;
      h_cnt         <= '0;
      de_cnt        <= '0;
      v_cnt         <= '0;
      va_cnt        <= '0;
      meas_h_active <= '0;
      meas_h_total  <= '0;
      meas_v_active <= '0;
      meas_v_total  <= '0;
      locked        <= 1'b0;
      timing_err    <= 1'b0;
    end else begin
      hs_prev     <= VGA_HS;
      vs_prev     <= VGA_VS;
      de_prev     <= data_en;
      pix_valid   <= data_en;
      line_start  <= de_rise;
      frame_start <= de_rise && new_frame;
      if (data_en) pix_x <= de_prev ? sat_inc(pix_x) : '0;
      if (de_rise) pix_y <= new_frame ? '0 : sat_inc(pix_y);
      if (vs_edge)      new_frame <= 1'b1;
      else if (de_rise) new_frame <= 1'b0;

      // Line measurements
      if (hs_edge) begin
        meas_h_total <= h_total_nxt;
        h_cnt        <= '0;
      end else begin
        h_cnt <= h_total_nxt;
      end
      if (de_fall) begin
        meas_h_active <= de_cnt;
        de_cnt        <= '0;
      end else if (data_en) begin
        de_cnt <= sat_inc(de_cnt);
      end

      // Frame measurements
      if (vs_edge) begin
        meas_v_total  <= v_total_nxt;
        meas_v_active <= v_active_nxt;
        v_cnt         <= '0;
        va_cnt        <= '0;
      end else begin
        v_cnt  <= v_total_nxt;
        va_cnt <= v_active_nxt;
      end

      locked     <= (state_nxt == LOCKED);
      timing_err <= mismatch;
    end
  end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor using a reduced 8x4 mode
// (12 clocks/line, 6 lines/frame) so that full frames stay short.
module tb_vga_timing_monitor;

  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          VGA_HS = 1'b1, VGA_VS = 1'b1, data_en = 1'b0;
  logic          pix_valid, line_start, frame_start, locked, timing_err;
  logic [CW-1:0] pix_x, pix_y, meas_h_active, meas_h_total, meas_v_active, meas_v_total;

  vga_timing_monitor #(
    .H_ACTIVE(8), .H_TOTAL(12), .V_ACTIVE(4), .V_TOTAL(6),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW)
  ) dut (
    .pixel_clk(clk), .rst(rst), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .data_en(data_en),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .line_start(line_start), .frame_start(frame_start),
    .meas_h_active(meas_h_active), .meas_h_total(meas_h_total),
    .meas_v_active(meas_v_active), .meas_v_total(meas_v_total),
    .locked(locked), .timing_err(timing_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int cyc = 0, frame_cyc = 0;
  logic rst_drv = 1'b1, chk_drv = 1'b0, chk_on = 1'b0;
  logic exp_valid = 1'b0, exp_fs = 1'b0, exp_ls = 1'b0;
  int exp_x = 0, exp_y = 0;
  int err_cnt = 0, last_err_cyc = -1, lock_rise_cyc = -1;
  int fs_cnt = 0, ls_cnt = 0, coord_bad = 0;
  logic locked_at_err = 1'b0, locked_q = 1'b0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic hs, input logic vs, input logic de,
                      input int x, input int y, input logic fs);
    @(negedge clk);
    rst       = rst_drv;
    chk_on    = chk_drv;
    VGA_HS    = hs;
    VGA_VS    = vs;
    data_en   = de;
    exp_valid = de;
    exp_x     = x;
    exp_y     = y;
    exp_fs    = fs;
    exp_ls    = de && (x == 0);
    cyc++;
  endtask

  task automatic idle();
    step(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
  endtask

  // HS low at h=0..1, VS low on line 0, data_en on lines 1..4 from h=3
  task automatic run_line(input int line, input int de_len, input int ncyc);
    for (int h = 0; h < ncyc; h++) begin
      logic hs_l, vs_l, de_l;
      hs_l = (h < 2) ? 1'b0 : 1'b1;
      vs_l = (line == 0) ? 1'b0 : 1'b1;
      de_l = (line >= 1) && (line <= 4) && (h >= 3) && (h < 3 + de_len);
      step(hs_l, vs_l, de_l, h - 3, line - 1, de_l && (line == 1) && (h == 3));
    end
  endtask

  task automatic run_frame(input int nlines, input int short_line);
    frame_cyc = cyc + 1;
    for (int l = 0; l < nlines; l++) run_line(l, (l == short_line) ? 7 : 8, 12);
  endtask

  always @(posedge clk) begin
    #1;
    if (timing_err) begin
      err_cnt++;
      last_err_cyc  = cyc;
      locked_at_err = locked;
    end
    if (locked && !locked_q) lock_rise_cyc = cyc;
    locked_q = locked;
    if (frame_start) fs_cnt++;
    if (line_start) ls_cnt++;
    if (chk_on) begin
      if (pix_valid !== exp_valid || frame_start !== exp_fs || line_start !== exp_ls)
        coord_bad++;
      if (exp_valid && (int'(pix_x) != exp_x || int'(pix_y) != exp_y))
        coord_bad++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, fs0, ls0, vs_b, vs_d, vs_h;
    repeat (3) idle();
    rst_drv = 1'b0;
    run_line(1, 8, 12);
    run_line(1, 8, 12);
    run_line(1, 8, 6);
    @(posedge clk); #2;
    check("pre_rst_valid", pix_valid, 1);

    // Reset held mid-line
    e0 = err_cnt;
    rst_drv = 1'b1;
    step(1'b1, 1'b1, 1'b1, 0, 0, 1'b0);
    @(posedge clk); #2;
    check("rst_outputs_zero", |{pix_valid, pix_x, pix_y, line_start, frame_start,
          meas_h_active, meas_h_total, meas_v_active, meas_v_total, locked, timing_err}, 0);
    repeat (19) step(1'b1, 1'b1, 1'b1, 0, 0, 1'b0);
    check("rst_no_err", err_cnt - e0, 0);
    check("rst_locked", locked, 0);
    rst_drv = 1'b0;
    chk_drv = 1'b1;
    repeat (2) idle();

    // Nominal stream: lock one cycle after the second VS leading edge
    e0 = err_cnt;
    run_frame(6, -1);
    check("measure_not_locked", locked, 0);
    run_frame(6, -1);
    vs_b = frame_cyc;
    check("lock_cycle", lock_rise_cyc, vs_b);
    fs0 = fs_cnt;
    ls0 = ls_cnt;
    run_frame(6, -1);
    check("meas_h_active", meas_h_active, 8);
    check("meas_h_total", meas_h_total, 12);
    check("meas_v_active", meas_v_active, 4);
    check("meas_v_total", meas_v_total, 6);
    check("nominal_no_err", err_cnt - e0, 0);
    check("frame_start_count", fs_cnt - fs0, 1);
    check("line_start_count", ls_cnt - ls0, 4);
    check("coord_errors", coord_bad, 0);
    check("still_locked", locked, 1);

    // Short active line while locked
    e0 = err_cnt;
    run_frame(6, 2);
    vs_d = frame_cyc;
    check("short_err_count", err_cnt - e0, 1);
    check("short_err_cycle", last_err_cyc, vs_d + 2 * 12 + 10);
    check("short_unlock_same_cycle", locked_at_err, 0);
    run_frame(6, -1);
    check("short_relock_wait", locked, 0);
    run_frame(6, -1);
    check("short_relocked", locked, 1);
    check("short_single_err", err_cnt - e0, 1);

    // Frame one line short
    e0 = err_cnt;
    run_frame(5, -1);
    check("short_frame_no_early_err", err_cnt - e0, 0);
    run_frame(6, -1);
    vs_h = frame_cyc;
    check("vshort_err_count", err_cnt - e0, 1);
    check("vshort_err_cycle", last_err_cyc, vs_h);
    check("vshort_unlock", locked_at_err, 0);
    check("vshort_meas_v_total", meas_v_total, 5);
    run_frame(6, -1);
    check("vshort_back_to_search", locked, 0);
    run_frame(6, -1);
    check("vshort_relocked", locked, 1);

    // HS missing for 5000 cycles: line counter saturates
    e0 = err_cnt;
    repeat (5000) idle();
    check("sat_no_err_yet", err_cnt - e0, 0);
    step(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    repeat (3) idle();
    check("sat_meas_h_total", meas_h_total, 4095);
    check("sat_err_count", err_cnt - e0, 1);
    check("sat_err_cycle", last_err_cyc, cyc - 3);
    check("sat_unlock", locked, 0);
    check("final_coord_errors", coord_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
